// File: rtl/adc_capture_sequencer.sv
// rtl/adc_capture_sequencer.sv - paced SPI ADC capture sequencer with framed valid/ready sample output
module adc_capture_sequencer #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  sample_period,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              clear_err,
    input  logic              adc_cs,
    input  logic [DATA_W-1:0] adc_data,
    output logic              startCapture,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              sample_first,
    output logic              sample_last,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_LATCH
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  frame_len_q, frame_len_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic [CNT_W-1:0]  period_cnt_dec;
    logic              period_done;
    logic              wd_done;
    logic              frame_end;
    logic              in_latch;
    logic              timeout_evt;
    logic              overrun_evt;

    // The START cycle itself is one period cycle, so ARM fires as the counter is about to hit zero.
    assign period_cnt_dec = (period_cnt_q == '0) ? '0 : period_cnt_q - CNT_ONE;
    assign period_done    = (period_cnt_dec == '0);
    assign wd_done        = (wd_q == WD_LAST);
    assign frame_end      = (frame_len_q != '0) && (index_q == frame_len_q - CNT_ONE);
    assign in_latch       = (state_q == S_LATCH);
    assign timeout_evt    = wd_done && (((state_q == S_WAIT_LO) && adc_cs) ||
                                        ((state_q == S_WAIT_HI) && !adc_cs));
    assign overrun_evt    = in_latch && valid_q && !sample_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_ARM;
            S_ARM: begin
                if (!enable)          state_d = S_IDLE;
                else if (period_done) state_d = S_START;
            end
            S_START:   state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!adc_cs)      state_d = S_WAIT_HI;
                else if (wd_done) state_d = S_ARM;
            end
            S_WAIT_HI: begin
                if (adc_cs)       state_d = S_LATCH;
                else if (wd_done) state_d = S_ARM;
            end
            S_LATCH:   state_d = S_ARM;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        startCapture = (state_q == S_START);
        busy         = (state_q != S_IDLE);
    end

    always_comb begin
        period_cnt_d = period_cnt_dec;
        if (state_q == S_START) begin
            period_cnt_d = (period_q > CNT_ONE) ? period_q - CNT_ONE : '0;
        end

        period_d    = period_q;
        frame_len_d = frame_len_q;
        index_d     = index_q;
        if ((state_q == S_IDLE) && enable) begin
            period_d    = sample_period;
            frame_len_d = frame_len;
            index_d     = '0;
        end else if (in_latch) begin
            if (frame_end) begin
                period_d    = sample_period;
                frame_len_d = frame_len;
                index_d     = '0;
            end else begin
                index_d = index_q + CNT_ONE;
            end
        end

        // Watchdog restarts on every entry into a wait phase.
        wd_d = '0;
        if (((state_q == S_WAIT_LO) || (state_q == S_WAIT_HI)) && (state_d == state_q)) begin
            wd_d = wd_q + CNT_ONE;
        end

        data_d  = data_q;
        first_d = first_q;
        last_d  = last_q;
        valid_d = valid_q && !sample_ready;
        if (in_latch) begin
            data_d  = adc_data;
            valid_d = 1'b1;
            first_d = (index_q == '0);
            last_d  = frame_end;
        end

        overrun_d = (overrun_q && !clear_err) || overrun_evt;
        timeout_d = (timeout_q && !clear_err) || timeout_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt_q <= '0;
            period_q     <= '0;
            frame_len_q  <= '0;
            index_q      <= '0;
            wd_q         <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            period_q     <= period_d;
            frame_len_q  <= frame_len_d;
            index_q      <= index_d;
            wd_q         <= wd_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign sample_first = first_q;
    assign sample_last  = last_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb/tb_adc_capture_sequencer.sv - directed self-checking bench for adc_capture_sequencer
module tb_adc_capture_sequencer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [CNT_W-1:0]  sample_period;
    logic [CNT_W-1:0]  frame_len;
    logic              clear_err;
    logic              adc_cs = 1'b1;
    logic [DATA_W-1:0] adc_data = '0;
    logic              startCapture;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              sample_first;
    logic              sample_last;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         starts[$];
    logic [9:0] samples[$];
    int         st_base;
    int         sm_base;

    logic adc_mode;
    int   cs_low_len;
    int   byte_base;
    int   byte_step;
    int   conv_n = 0;
    int   conv_base;
    int   lo_cnt = 0;

    int   t_err;
    logic saw_valid;

    adc_capture_sequencer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_period(sample_period),
        .frame_len    (frame_len),
        .clear_err    (clear_err),
        .adc_cs       (adc_cs),
        .adc_data     (adc_data),
        .startCapture (startCapture),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_first (sample_first),
        .sample_last  (sample_last),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // ADC model reacts half a cycle after startCapture and holds cs low for cs_low_len cycles.
    always @(negedge clk) begin
        if (startCapture) starts.push_back(cyc);
        if (sample_valid && sample_ready) samples.push_back({sample_first, sample_last, sample_data});
        if (adc_mode && startCapture) begin
            adc_cs   = 1'b0;
            lo_cnt   = cs_low_len - 1;
            adc_data = 8'(byte_base + byte_step * (conv_n - conv_base));
            conv_n   = conv_n + 1;
        end else if (!adc_cs) begin
            if (lo_cnt == 0) adc_cs = 1'b1;
            else lo_cnt = lo_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input string tag, input int n, input int bound);
        int k = 0;
        while (((starts.size() - st_base) < n) && (k < bound)) begin
            step(1);
            k++;
        end
        chk(tag, 32'((starts.size() - st_base) >= n), 32'd1);
    endtask

    task automatic wait_samples(input string tag, input int n, input int bound);
        int k = 0;
        while (((samples.size() - sm_base) < n) && (k < bound)) begin
            step(1);
            k++;
        end
        chk(tag, 32'((samples.size() - sm_base) >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        while (busy && (k < bound)) begin
            step(1);
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic new_test(input int base, input int stp);
        byte_base = base;
        byte_step = stp;
        conv_base = conv_n;
        st_base   = starts.size();
        sm_base   = samples.size();
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        enable        = 1'b0;
        sample_period = '0;
        frame_len     = '0;
        clear_err     = 1'b0;
        sample_ready  = 1'b0;
        adc_mode      = 1'b1;
        cs_low_len    = 4;
        byte_base     = 0;
        byte_step     = 1;
        conv_base     = 0;
        st_base       = 0;
        sm_base       = 0;
        step(3);
        chk("reset_outputs", 32'({startCapture, sample_valid, sample_first, sample_last,
                                  busy, overrun, timeout_err, sample_data}), 32'd0);
        reset = 1'b1;
        step(1);

        // T1: period 10, frame of 3
        sample_period = 16'd10;
        frame_len     = 16'd3;
        sample_ready  = 1'b1;
        new_test(32'hA0, 1);
        enable = 1'b1;
        wait_starts("t1_starts", 7, 200);
        for (int i = 1; i < 7; i++)
            chk($sformatf("t1_spacing%0d", i), 32'(starts[st_base+i] - starts[st_base+i-1]), 32'd10);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_sample%0d", i), 32'(samples[sm_base+i]),
                32'({(i % 3 == 0), (i % 3 == 2), 8'(32'hA0 + i)}));
        enable = 1'b0;
        wait_idle("t1_idle", 50);

        // T2: back-to-back, spacing = conversion + 3
        sample_period = 16'd0;
        frame_len     = 16'd0;
        new_test(0, 1);
        enable = 1'b1;
        wait_starts("t2_starts", 4, 100);
        enable = 1'b0;
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2_spacing%0d", i), 32'(starts[st_base+i] - starts[st_base+i-1]), 32'd7);
        chk("t2_no_overrun", 32'(overrun), 32'd0);
        wait_idle("t2_idle", 50);

        // T3: overrun with ready low, then clear_err
        sample_ready = 1'b0;
        new_test(32'h11, 32'h11);
        enable = 1'b1;
        wait_starts("t3_starts", 2, 50);
        enable = 1'b0;
        wait_idle("t3_idle", 50);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_data", 32'(sample_data), 32'h22);
        chk("t3_valid", 32'(sample_valid), 32'd1);
        pulse_clear();
        chk("t3_overrun_cleared", 32'(overrun), 32'd0);
        chk("t3_data_hold", 32'(sample_data), 32'h22);
        sample_ready = 1'b1;
        step(1);
        chk("t3_valid_consumed", 32'(sample_valid), 32'd0);

        // T4: cs never falls, watchdog fires
        adc_mode = 1'b0;
        new_test(0, 1);
        enable = 1'b1;
        wait_starts("t4_first_start", 1, 20);
        t_err     = -1;
        saw_valid = 1'b0;
        for (int k = 0; (k < 400) && (t_err < 0); k++) begin
            @(negedge clk);
            if (sample_valid) saw_valid = 1'b1;
            if (timeout_err) t_err = cyc;
        end
        chk("t4_timeout_latency", 32'(t_err - starts[st_base]), 32'd256);
        wait_starts("t4_restart", 2, 20);
        chk("t4_restart_spacing", 32'(starts[st_base+1] - starts[st_base]), 32'd257);
        enable = 1'b0;
        wait_idle("t4_idle", 400);
        chk("t4_no_samples", 32'(samples.size() - sm_base), 32'd0);
        chk("t4_no_valid", 32'(saw_valid), 32'd0);
        pulse_clear();
        chk("t4_timeout_cleared", 32'(timeout_err), 32'd0);
        adc_mode = 1'b1;

        // T5: enable dropped during WAIT_HI of the second sample of a 4-sample frame
        frame_len = 16'd4;
        new_test(32'h50, 1);
        enable = 1'b1;
        wait_starts("t5_starts", 2, 50);
        step(2);
        enable = 1'b0;
        wait_idle("t5_idle", 50);
        chk("t5_delivered_count", 32'(samples.size() - sm_base), 32'd2);
        chk("t5_sample1", 32'(samples[sm_base+1]), 32'h051);
        enable = 1'b1;
        wait_samples("t5_resume", 3, 50);
        chk("t5_fresh_first", 32'(samples[sm_base+2]), 32'h252);
        enable = 1'b0;
        wait_idle("t5_idle2", 50);

        // T6: asynchronous reset during WAIT_LO with a pending sample
        sample_ready = 1'b0;
        frame_len    = 16'd0;
        new_test(32'h70, 1);
        enable = 1'b1;
        wait_starts("t6_starts", 2, 50);
        chk("t6_pre_valid", 32'(sample_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_outputs", 32'({startCapture, sample_valid, sample_first, sample_last,
                                     busy, overrun, timeout_err, sample_data}), 32'd0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("t6_cycle1", 32'({startCapture, busy}), 32'b01);
        step(1);
        chk("t6_cycle2_start", 32'(startCapture), 32'd1);
        enable       = 1'b0;
        sample_ready = 1'b1;
        wait_idle("t6_idle", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
